puf_eval_ctrl: RTL and testbench

//  Sequences the 64-bit arbiter-PUF array: applies a challenge, pulses the array reset, waits for the

---
 rtl/puf_eval_ctrl_pkg.sv | 32 +++
 rtl/puf_vote_acc.sv | 43 ++++
 rtl/puf_eval_ctrl.sv | 153 +++++++++++++++
 tb/tb_puf_eval_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/puf_eval_ctrl_pkg.sv
// rtl/puf_eval_ctrl_pkg.sv - shared types, default timings and width helpers for the PUF evaluation controller
//
// Purpose: FSM state encoding, default parameter values and the vote-counter
//          width helper, shared by puf_eval_ctrl and puf_vote_acc.
// Ports:   none (package)

package puf_eval_ctrl_pkg;

    localparam int DEF_RSP_W      = 64;
    localparam int DEF_CHAL_W     = 64;
    localparam int DEF_SETTLE_CYC = 16;
    localparam int DEF_EVAL_CYC   = 32;
    localparam int DEF_N_VOTE     = 7;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_EVAL   = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_VOTE   = 3'd4
    } state_t;

    // Bits needed to hold a vote count of 0..n_vote inclusive.
    function automatic int cnt_w(input int n_vote);
        return (n_vote < 1) ? 1 : $clog2(n_vote + 1);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/puf_vote_acc.sv
// rtl/puf_vote_acc.sv - per-bit vote accumulator for the PUF majority voter
//
// Purpose: counts how many rounds a single PUF bit read as 1 and reports the
//          majority decision and whether the bit ever disagreed.
// Ports:
//   clk       in   1  system clock
//   rst_n     in   1  asynchronous active-low reset
//   clear     in   1  zero the count (start of a request)
//   inc       in   1  add one to the count (bit read 1 in this round)
//   maj       out  1  count is more than half of N_VOTE
//   unstable  out  1  count is neither 0 nor N_VOTE

module puf_vote_acc
    import puf_eval_ctrl_pkg::*;
#(
    parameter int N_VOTE = DEF_N_VOTE,
    parameter int CNT_W  = cnt_w(DEF_N_VOTE)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    output logic maj,
    output logic unstable
);

    logic [CNT_W-1:0] cnt;

    // The round counter in the controller stops at N_VOTE, so cnt never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign maj      = (cnt > CNT_W'(N_VOTE / 2));
    assign unstable = (cnt != '0) && (cnt != CNT_W'(N_VOTE));

endmodule

// File: rtl/puf_eval_ctrl.sv
// rtl/puf_eval_ctrl.sv - arbiter-PUF evaluation sequencer with majority voting
//
// Purpose: applies a challenge to the arbiter-PUF array, cycles the array reset
//          N_VOTE times, samples the synchronised response each round and
//          publishes a majority-voted response plus a per-bit instability mask.
// Ports:
//   clk            in   1       system clock
//   rst_n          in   1       asynchronous active-low reset
//   start          in   1       request evaluation (accepted only when idle)
//   challenge_in   in   CHAL_W  challenge, captured on the accepted start
//   puf_chal       out  CHAL_W  challenge driven to the array
//   puf_rst        out  1       array reset, high clears the arbiters
//   puf_rsp        in   RSP_W   raw array response, asynchronous to clk
//   busy           out  1       evaluation in progress
//   done           out  1       one-cycle pulse, result published
//   rsp_valid      out  1       rsp_out/unstable_mask valid until next accept
//   rsp_out        out  RSP_W   majority-voted response
//   unstable_mask  out  RSP_W   1 where a bit disagreed between rounds

module puf_eval_ctrl
    import puf_eval_ctrl_pkg::*;
#(
    parameter int RSP_W      = DEF_RSP_W,
    parameter int CHAL_W     = DEF_CHAL_W,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int EVAL_CYC   = DEF_EVAL_CYC,
    parameter int N_VOTE     = DEF_N_VOTE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CHAL_W-1:0] challenge_in,
    output logic [CHAL_W-1:0] puf_chal,
    output logic              puf_rst,
    input  logic [RSP_W-1:0]  puf_rsp,
    output logic              busy,
    output logic              done,
    output logic              rsp_valid,
    output logic [RSP_W-1:0]  rsp_out,
    output logic [RSP_W-1:0]  unstable_mask
);

    localparam int CNT_W = cnt_w(N_VOTE);
    localparam int TMR_W = $clog2(max2(SETTLE_CYC, EVAL_CYC) + 1);

    state_t             state, state_nxt;
    logic [TMR_W-1:0]   timer;
    logic [CNT_W-1:0]   round;
    logic [RSP_W-1:0]   rsp_meta, rsp_sync;
    logic [RSP_W-1:0]   maj_vec, unst_vec;
    logic               accept, acc_inc, publish;

    // Free-running two-flop synchroniser; the array output has no relation to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_meta <= '0;
            rsp_sync <= '0;
        end else begin
            rsp_meta <= puf_rsp;
            rsp_sync <= rsp_meta;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        acc_inc   = 1'b0;
        publish   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = ST_ARM;
                end
            end
            ST_ARM: begin
                if (timer == TMR_W'(SETTLE_CYC - 1)) begin
                    state_nxt = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (timer == TMR_W'(EVAL_CYC - 1)) begin
                    state_nxt = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                acc_inc   = 1'b1;
                state_nxt = (round == CNT_W'(N_VOTE - 1)) ? ST_VOTE : ST_ARM;
            end
            ST_VOTE: begin
                publish   = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            timer         <= '0;
            round         <= '0;
            puf_chal      <= '0;
            puf_rst       <= 1'b1;
            done          <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_out       <= '0;
            unstable_mask <= '0;
        end else begin
            state <= state_nxt;
            // Timer restarts on every state change, including SAMPLE -> ARM.
            if ((state_nxt != state) || (state == ST_IDLE)) begin
                timer <= '0;
            end else begin
                timer <= timer + TMR_W'(1);
            end
            // Registered from next state so the array reset never glitches.
            puf_rst <= (state_nxt != ST_EVAL);
            done    <= publish;
            if (accept) begin
                puf_chal  <= challenge_in;
                round     <= '0;
                rsp_valid <= 1'b0;
            end else if (acc_inc) begin
                round <= round + CNT_W'(1);
            end
            if (publish) begin
                rsp_out       <= maj_vec;
                unstable_mask <= unst_vec;
                rsp_valid     <= 1'b1;
            end
        end
    end

    assign busy = (state != ST_IDLE);

    for (genvar i = 0; i < RSP_W; i++) begin : g_acc
        puf_vote_acc #(
            .N_VOTE (N_VOTE),
            .CNT_W  (CNT_W)
        ) u_acc (
            .clk      (clk),
            .rst_n    (rst_n),
            .clear    (accept),
            .inc      (acc_inc & rsp_sync[i]),
            .maj      (maj_vec[i]),
            .unstable (unst_vec[i])
        );
    end

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// tb/tb_puf_eval_ctrl.sv - self-checking bench for puf_eval_ctrl

module tb_puf_eval_ctrl;

    localparam int SC = 4;
    localparam int EC = 8;
    localparam int RND = SC + EC + 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a, start_b;
    logic [63:0] challenge_in;
    logic [63:0] puf_rsp;

    logic [63:0] puf_chal_a, rsp_out_a, mask_a;
    logic        puf_rst_a, busy_a, done_a, valid_a;
    logic [63:0] puf_chal_b, rsp_out_b, mask_b;
    logic        puf_rst_b, busy_b, done_b, valid_b;

    always #5 clk = ~clk;

    puf_eval_ctrl #(.RSP_W(64), .CHAL_W(64), .SETTLE_CYC(SC), .EVAL_CYC(EC), .N_VOTE(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .challenge_in(challenge_in),
        .puf_chal(puf_chal_a), .puf_rst(puf_rst_a), .puf_rsp(puf_rsp), .busy(busy_a),
        .done(done_a), .rsp_valid(valid_a), .rsp_out(rsp_out_a), .unstable_mask(mask_a)
    );

    puf_eval_ctrl #(.RSP_W(64), .CHAL_W(64), .SETTLE_CYC(SC), .EVAL_CYC(EC), .N_VOTE(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .challenge_in(challenge_in),
        .puf_chal(puf_chal_b), .puf_rst(puf_rst_b), .puf_rsp(puf_rsp), .busy(busy_b),
        .done(done_b), .rsp_valid(valid_b), .rsp_out(rsp_out_b), .unstable_mask(mask_b)
    );

    int          checks = 0;
    int          failures = 0;
    bit          cur = 1'b0;
    logic [63:0] rnd_val [15];

    logic [63:0] o_chal, o_rsp, o_mask;
    logic        o_rst, o_busy, o_done, o_valid;
    assign o_chal  = cur ? puf_chal_b : puf_chal_a;
    assign o_rsp   = cur ? rsp_out_b  : rsp_out_a;
    assign o_mask  = cur ? mask_b     : mask_a;
    assign o_rst   = cur ? puf_rst_b  : puf_rst_a;
    assign o_busy  = cur ? busy_b     : busy_a;
    assign o_done  = cur ? done_b     : done_a;
    assign o_valid = cur ? valid_b    : valid_a;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (cur) start_b = v;
        else     start_a = v;
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    // Majority and disagreement computed directly from the per-round values.
    task automatic ref_vote(input int nv, output logic [63:0] maj, output logic [63:0] unst);
        for (int b = 0; b < 64; b++) begin
            int ones = 0;
            for (int r = 0; r < nv; r++) ones += int'(rnd_val[r][b]);
            maj[b]  = (2 * ones > nv);
            unst[b] = (ones != 0) && (ones != nv);
        end
    endtask

    // One request. Cycle j is the cycle after accept edge k; done is due at j == T.
    task automatic run_req(input int nv, input logic [63:0] chal, input bit toggle,
                           input bit prestarted, input bit hold, input logic [63:0] next_chal);
        int          t;
        logic        exp_rst;
        logic [63:0] e_maj, e_unst;
        t = nv * RND + 1;
        if (!prestarted) begin
            @(negedge clk);
            challenge_in = chal;
            set_start(1'b1);
        end
        @(posedge clk);
        for (int j = 0; j <= t; j++) begin
            @(negedge clk);
            if (j >= nv * RND) exp_rst = 1'b1;
            else exp_rst = !(((j % RND) >= SC) && ((j % RND) < SC + EC));
            chk("busy",      64'(o_busy),  64'(j < t));
            chk("done",      64'(o_done),  64'(j == t));
            chk("rsp_valid", 64'(o_valid), 64'(j == t));
            chk("puf_rst",   64'(o_rst),   64'(exp_rst));
            chk("puf_chal",  o_chal,       chal);
            if (j == 0 && !hold) set_start(1'b0);
            if ((j % RND) == 1 && (j / RND) < nv) puf_rsp = rnd_val[j / RND];
            if (toggle && j >= 1 && j < t - 1) begin
                set_start(1'($urandom));
                challenge_in = rand64();
            end
            if (j >= t - 1 && !hold) set_start(1'b0);
            if (j == t) begin
                ref_vote(nv, e_maj, e_unst);
                chk("rsp_out",       o_rsp,  e_maj);
                chk("unstable_mask", o_mask, e_unst);
                if (hold) challenge_in = next_chal;
            end
        end
    endtask

    initial begin
        logic [63:0] c1, c2;
        rst_n = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        challenge_in = '0;
        puf_rsp = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy",  64'(busy_a),    64'd0);
        chk("rst_puf",   64'(puf_rst_a), 64'd1);
        chk("rst_done",  64'(done_a),    64'd0);
        chk("rst_valid", 64'(valid_a),   64'd0);
        chk("rst_rsp",   rsp_out_a,      64'd0);
        chk("rst_mask",  mask_a,         64'd0);
        chk("rst_chal",  puf_chal_a,     64'd0);
        rst_n = 1'b1;

        // Constant response: every bit stable.
        for (int r = 0; r < 3; r++) rnd_val[r] = 64'hDEADBEEF_01234567;
        run_req(3, rand64(), 1'b0, 1'b0, 1'b0, '0);
        chk("const_rsp",  rsp_out_a, 64'hDEADBEEF_01234567);
        chk("const_mask", mask_a,    64'd0);

        // Bit 0 reads 1,0,1 and bit 5 reads 0,1,1.
        rnd_val[0] = 64'h01;
        rnd_val[1] = 64'h20;
        rnd_val[2] = 64'h21;
        run_req(3, rand64(), 1'b0, 1'b0, 1'b0, '0);
        chk("dir_rsp",  rsp_out_a, 64'h21);
        chk("dir_mask", mask_a,    64'h21);

        // Random responses while start/challenge_in toggle during busy.
        for (int n = 0; n < 3; n++) begin
            for (int r = 0; r < 3; r++) rnd_val[r] = rand64();
            run_req(3, rand64(), 1'b1, 1'b0, 1'b0, '0);
        end

        // start held high: second request accepted straight after done.
        c1 = rand64();
        c2 = rand64();
        for (int r = 0; r < 3; r++) rnd_val[r] = rand64();
        run_req(3, c1, 1'b0, 1'b0, 1'b1, c2);
        for (int r = 0; r < 3; r++) rnd_val[r] = rand64();
        run_req(3, c2, 1'b0, 1'b1, 1'b0, '0);

        // Reset during the second EVAL window aborts at once.
        @(negedge clk);
        challenge_in = rand64();
        start_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        repeat (RND + SC + 1) @(negedge clk);
        chk("pre_rst_eval", 64'(puf_rst_a), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("abort_busy",  64'(busy_a),    64'd0);
        chk("abort_puf",   64'(puf_rst_a), 64'd1);
        chk("abort_valid", 64'(valid_a),   64'd0);
        chk("abort_rsp",   rsp_out_a,      64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int r = 0; r < 3; r++) rnd_val[r] = rand64();
        run_req(3, rand64(), 1'b0, 1'b0, 1'b0, '0);

        // Single-vote instance: 14-cycle latency, never unstable.
        cur = 1'b1;
        for (int n = 0; n < 2; n++) begin
            rnd_val[0] = rand64();
            run_req(1, rand64(), 1'b0, 1'b0, 1'b0, '0);
            chk("nv1_mask", mask_b,    64'd0);
            chk("nv1_rsp",  rsp_out_b, rnd_val[0]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
